// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational Hack ALU between N requesters. Requests are
//   granted round-robin. The ALU is driven from registered operands, and the
//   result is returned with zero/negative flags over a valid/ready handshake.
//
// Parameters
//   N  number of requesters (2..8)
//   W  datapath width, must match the ALU
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   req_valid   [N]    request pending per requester
//   req_ready   [N]    one-hot combinational grant, IDLE only
//   req_op      [6N]   control words {Zx,Nx,Zy,Ny,f,No}, requester i at [6i+5:6i]
//   req_x/y     [W*N]  operands, requester i at [Wi+W-1:Wi]
//   resp_valid  [N]    one-hot response valid, held until accepted
//   resp_ready  [N]    response accept; only the granted bit is honoured
//   resp_data   [W]    shared result
//   resp_zr     result is zero
//   resp_ng     result sign bit
//   resp_err    request carried an illegal control word
//   alu_ctrl    [6]    registered ALU control word
//   alu_x/y     [W]    registered ALU operands
//   alu_out     [W]    combinational ALU result
//   busy        high in any state other than IDLE
module alu_arbiter #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [6*N-1:0] req_op,
  input  logic [W*N-1:0] req_x,
  input  logic [W*N-1:0] req_y,
  output logic [N-1:0]   resp_valid,
  input  logic [N-1:0]   resp_ready,
  output logic [W-1:0]   resp_data,
  output logic           resp_zr,
  output logic           resp_ng,
  output logic           resp_err,
  output logic [5:0]     alu_ctrl,
  output logic [W-1:0]   alu_x,
  output logic [W-1:0]   alu_y,
  input  logic [W-1:0]   alu_out,
  output logic           busy
);

  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_q, gnt_d;
  logic [5:0]    ctrl_q, ctrl_d;
  logic [W-1:0]  x_q, x_d, y_q, y_d;
  logic [W-1:0]  data_q, data_d;
  logic          zr_q, zr_d, ng_q, ng_d, err_q, err_d;

  logic          found;
  logic [PW-1:0] g;
  logic [5:0]    op_sel;
  logic [W-1:0]  x_sel, y_sel;
  logic          op_ok;

  // The 18 control words that the Hack ALU defines; anything else is rejected.
  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
      6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
      6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000,
      6'b010101: is_legal = 1'b1;
      default:   is_legal = 1'b0;
    endcase
  endfunction

  // Round-robin search: first set req_valid bit at or after ptr, wrapping.
  always_comb begin
    int idx;
    found = 1'b0;
    g     = ptr_q;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        g     = PW'(idx);
      end
    end
  end

  always_comb begin
    int gi;
    gi     = int'(g);
    op_sel = req_op[6*gi +: 6];
    x_sel  = req_x[W*gi +: W];
    y_sel  = req_y[W*gi +: W];
    op_ok  = is_legal(op_sel);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = op_ok ? ISSUE : RESP;
      ISSUE:   state_d = RESP;
      RESP:    if (resp_ready[gnt_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; req_ready is gated by rst so it reads 0 while reset is held.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (state_q == IDLE && found && !rst) req_ready[g] = 1'b1;
    if (state_q == RESP) resp_valid[gnt_q] = 1'b1;
    busy = (state_q != IDLE);
  end

  // Datapath next state. Illegal ops skip ISSUE and leave the ALU ports alone.
  always_comb begin
    ptr_d  = ptr_q;
    gnt_d  = gnt_q;
    ctrl_d = ctrl_q;
    x_d    = x_q;
    y_d    = y_q;
    data_d = data_q;
    zr_d   = zr_q;
    ng_d   = ng_q;
    err_d  = err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d = g;
          if (op_ok) begin
            ctrl_d = op_sel;
            x_d    = x_sel;
            y_d    = y_sel;
          end else begin
            data_d = '0;
            zr_d   = 1'b1;
            ng_d   = 1'b0;
            err_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        data_d = alu_out;
        zr_d   = (alu_out == '0);
        ng_d   = alu_out[W-1];
        err_d  = 1'b0;
      end
      RESP: begin
        if (resp_ready[gnt_q])
          ptr_d = (gnt_q == PW'(N-1)) ? '0 : gnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      gnt_q  <= '0;
      ctrl_q <= 6'b101010;
      x_q    <= '0;
      y_q    <= '0;
      data_q <= '0;
      zr_q   <= 1'b0;
      ng_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      ctrl_q <= ctrl_d;
      x_q    <= x_d;
      y_q    <= y_d;
      data_q <= data_d;
      zr_q   <= zr_d;
      ng_q   <= ng_d;
      err_q  <= err_d;
    end
  end

  assign alu_ctrl  = ctrl_q;
  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign resp_data = data_q;
  assign resp_zr   = zr_q;
  assign resp_ng   = ng_q;
  assign resp_err  = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [6*N-1:0] req_op;
  logic [W*N-1:0] req_x, req_y;
  logic [W-1:0]   resp_data, alu_x, alu_y, alu_out;
  logic           resp_zr, resp_ng, resp_err, busy;
  logic [5:0]     alu_ctrl;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         id;
    logic [W-1:0] data;
    logic       zr;
    logic       ng;
    logic       err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Reference Hack ALU; also serves as the ALU attached to the DUT.
  function automatic logic [W-1:0] hack(input logic [5:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] a, b, o;
    a = c[5] ? '0 : x;
    if (c[4]) a = ~a;
    b = c[3] ? '0 : y;
    if (c[2]) b = ~b;
    o = c[1] ? a + b : a & b;
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign alu_out = hack(alu_ctrl, alu_x, alu_y);

  alu_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_zr(resp_zr), .resp_ng(resp_ng), .resp_err(resp_err),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y), .alu_out(alu_out),
    .busy(busy)
  );

  task automatic set_req(input int id, input logic [5:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    req_op[6*id +: 6] = op;
    req_x[W*id +: W]  = x;
    req_y[W*id +: W]  = y;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for any resp_valid bit, sampling on falling edges.
  task automatic wait_resp(output bit to);
    to = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid !== '0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; resp_ready = '0; req_op = '0; req_x = '0; req_y = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({req_ready, resp_valid, busy} !== '0) begin
      bad++; $display("FAIL reset_ctrl got=%h want=0", {req_ready, resp_valid, busy});
    end
    total++;
    if ({resp_data, resp_zr, resp_ng, resp_err} !== '0) begin
      bad++; $display("FAIL reset_resp got=%h want=0", {resp_data, resp_zr, resp_ng, resp_err});
    end
    total++;
    if ({alu_ctrl, alu_x, alu_y} !== {6'b101010, {2*W{1'b0}}}) begin
      bad++; $display("FAIL reset_alu got=%h/%h/%h want=2a/0/0", alu_ctrl, alu_x, alu_y);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    exp_t e;
    @(negedge clk);
    resp_ready = '1;
    set_req(2, 6'b000010, 16'd5, 16'd7);
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++; $display("FAIL single_grant got=%b want=0100", req_ready);
    end
    e = '{2, 16'd12, 1'b0, 1'b0, 1'b0};
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    total++;
    if ({resp_valid, busy, alu_ctrl} !== {4'b0000, 1'b1, 6'b000010}) begin
      bad++; $display("FAIL single_issue got valid=%b busy=%b ctrl=%b want 0000/1/000010", resp_valid, busy, alu_ctrl);
    end
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (resp_valid !== 4'(1 << e.id) || {resp_data, resp_zr, resp_ng, resp_err} !== {e.data, e.zr, e.ng, e.err}) begin
      bad++; $display("FAIL single_resp got valid=%b data=%h zr=%b ng=%b err=%b want valid=0100 data=%h", resp_valid, resp_data, resp_zr, resp_ng, resp_err, e.data);
    end
    @(negedge clk);
    total++;
    if ({busy, resp_valid} !== '0) begin
      bad++; $display("FAIL single_done got busy=%b valid=%b want 0", busy, resp_valid);
    end
  endtask

  task automatic test_flags();
    logic [5:0]   ops[2] = '{6'b010011, 6'b101010};
    logic [W-1:0] exd[2] = '{16'hFFFE, 16'h0000};
    logic         ezr[2] = '{1'b0, 1'b1};
    logic         eng[2] = '{1'b1, 1'b0};
    exp_t e;
    bit to;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      resp_ready = '1;
      set_req(0, ops[k], 16'd3, 16'd5);
      req_valid = 4'b0001;
      e = '{0, exd[k], ezr[k], eng[k], 1'b0};
      sb.push_back(e);
      @(posedge clk);
      #1 req_valid = '0;
      wait_resp(to);
      total++;
      if (to) begin
        bad++; $display("FAIL flags_timeout op=%b got no resp_valid want resp", ops[k]);
      end else begin
        e = sb.pop_front();
        if (resp_valid !== 4'(1 << e.id) || {resp_data, resp_zr, resp_ng, resp_err} !== {e.data, e.zr, e.ng, e.err}) begin
          bad++; $display("FAIL flags op=%b got data=%h zr=%b ng=%b err=%b want data=%h zr=%b ng=%b err=0", ops[k], resp_data, resp_zr, resp_ng, resp_err, e.data, e.zr, e.ng);
        end
      end
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    @(negedge clk);
    resp_ready = '1;
    set_req(1, 6'b100000, 16'h1234, 16'h5678);
    req_valid = 4'b0010;
    e = '{1, 16'h0000, 1'b1, 1'b0, 1'b1};
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (resp_valid !== 4'(1 << e.id) || {resp_data, resp_zr, resp_ng, resp_err} !== {e.data, e.zr, e.ng, e.err}) begin
      bad++; $display("FAIL illegal_resp got valid=%b data=%h zr=%b ng=%b err=%b want 0010/0000/1/0/1", resp_valid, resp_data, resp_zr, resp_ng, resp_err);
    end
    total++;
    if ({alu_ctrl, alu_x, alu_y} !== {6'b101010, 16'd3, 16'd5}) begin
      bad++; $display("FAIL illegal_alu_kept got=%b/%h/%h want 101010/0003/0005", alu_ctrl, alu_x, alu_y);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit to;
    @(negedge clk);
    resp_ready = 4'b0111;
    for (int i = 0; i < 3; i++) set_req(i, 6'b000010, 16'h1, 16'h1);
    set_req(3, 6'b000010, 16'h7FFF, 16'h0001);
    req_valid = 4'b1000;
    e = '{3, 16'h8000, 1'b0, 1'b1, 1'b0};
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = '1;
    wait_resp(to);
    total++;
    if (to) begin
      bad++; $display("FAIL bp_timeout got no resp_valid want resp");
    end else begin
      e = sb.pop_front();
      if (resp_valid !== 4'(1 << e.id) || {resp_data, resp_zr, resp_ng, resp_err} !== {e.data, e.zr, e.ng, e.err}) begin
        bad++; $display("FAIL bp_resp got valid=%b data=%h ng=%b want 1000/8000/1", resp_valid, resp_data, resp_ng);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({resp_valid, busy, req_ready} !== {4'b1000, 1'b1, 4'b0000} || resp_data !== 16'h8000) begin
        bad++; $display("FAIL bp_hold cyc=%0d got valid=%b busy=%b ready=%b data=%h want 1000/1/0000/8000", i, resp_valid, busy, req_ready, resp_data);
      end
    end
    resp_ready = 4'b1111;
    @(posedge clk);
    #1 resp_ready = '0;
    @(negedge clk);
    total++;
    if ({busy, resp_valid, req_ready} !== {1'b0, 4'b0000, 4'b0001}) begin
      bad++; $display("FAIL bp_release got busy=%b valid=%b ready=%b want 0/0000/0001", busy, resp_valid, req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [5:0]   ops[4] = '{6'b000010, 6'b000111, 6'b000000, 6'b010101};
    logic [W-1:0] xs[4], ys[4];
    int ngr = 0, nrs = 0, last = 0, gid;
    exp_t e;
    do_reset();
    resp_ready = '1;
    for (int i = 0; i < 4; i++) begin
      xs[i] = W'(100 * (i + 1) + i);
      ys[i] = W'(16'h00F0 ^ i);
      set_req(i, ops[i], xs[i], ys[i]);
    end
    @(negedge clk);
    req_valid = '1;
    for (int c = 0; c < 40 && nrs < 5; c++) begin
      #1;
      if (req_ready !== '0) begin
        gid = -1;
        for (int b = 0; b < N; b++) if (req_ready[b] === 1'b1 && gid < 0) gid = b;
        total++;
        if (!$onehot(req_ready) || gid != ngr % 4 || (ngr > 0 && c - last != 3)) begin
          bad++; $display("FAIL rr_grant n=%0d got ready=%b gap=%0d want id=%0d gap=3", ngr, req_ready, c - last, ngr % 4);
        end
        if (gid >= 0) begin
          e = '{gid, hack(ops[gid], xs[gid], ys[gid]), 1'b0, 1'b0, 1'b0};
          e.zr = (e.data == '0);
          e.ng = e.data[W-1];
          sb.push_back(e);
        end
        last = c;
        ngr++;
      end
      if (resp_valid !== '0) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL rr_unexpected_resp got valid=%b want none", resp_valid);
        end else begin
          e = sb.pop_front();
          if (resp_valid !== 4'(1 << e.id) || {resp_data, resp_zr, resp_ng, resp_err} !== {e.data, e.zr, e.ng, e.err}) begin
            bad++; $display("FAIL rr_resp n=%0d got valid=%b data=%h zr=%b ng=%b err=%b want id=%0d data=%h", nrs, resp_valid, resp_data, resp_zr, resp_ng, resp_err, e.id, e.data);
          end
        end
        nrs++;
        if (nrs == 5) req_valid = '0;
      end
      @(negedge clk);
    end
    total++;
    if (nrs != 5 || ngr != 5) begin
      bad++; $display("FAIL rr_count got grants=%0d resps=%0d want 5/5", ngr, nrs);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit to;
    @(negedge clk);
    resp_ready = '0;
    set_req(2, 6'b001100, 16'h1111, 16'h2222);
    req_valid = 4'b0100;
    @(posedge clk);
    #1 req_valid = '0;
    wait_resp(to);
    total++;
    if (to) begin
      bad++; $display("FAIL rm_timeout got no resp_valid want resp");
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({req_ready, resp_valid, busy, resp_data, resp_zr, resp_ng, resp_err} !== '0) begin
      bad++; $display("FAIL rm_reset_outputs got ready=%b valid=%b busy=%b data=%h zr=%b ng=%b err=%b want 0", req_ready, resp_valid, busy, resp_data, resp_zr, resp_ng, resp_err);
    end
    total++;
    if ({alu_ctrl, alu_x, alu_y} !== {6'b101010, {2*W{1'b0}}}) begin
      bad++; $display("FAIL rm_reset_alu got=%b/%h/%h want 101010/0/0", alu_ctrl, alu_x, alu_y);
    end
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 6'b001100, 16'hABCD, 16'h0000);
    req_valid = 4'b0101;
    resp_ready = '1;
    #1;
    total++;
    if ({req_ready, resp_valid} !== {4'b0001, 4'b0000}) begin
      bad++; $display("FAIL rm_first_grant got ready=%b valid=%b want 0001/0000", req_ready, resp_valid);
    end
    e = '{0, 16'hABCD, 1'b0, 1'b1, 1'b0};
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = '0;
    wait_resp(to);
    total++;
    if (to) begin
      bad++; $display("FAIL rm_resp_timeout got no resp_valid want resp");
    end else begin
      e = sb.pop_front();
      if (resp_valid !== 4'(1 << e.id) || {resp_data, resp_zr, resp_ng, resp_err} !== {e.data, e.zr, e.ng, e.err}) begin
        bad++; $display("FAIL rm_resp got valid=%b data=%h ng=%b want 0001/abcd/1", resp_valid, resp_data, resp_ng);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_flags();
    test_illegal();
    test_backpressure();
    test_round_robin();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
